// File: rtl/mu_arbiter.sv
// Round-robin arbiter sharing one multiply/divide unit between NREQ requesters.
// Each requester has a single-entry response buffer; there is flush support and a completion watchdog.
package mu_pkg;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        MU_NOP    = 4'd0,
        MU_MUL    = 4'd1,
        MU_MULH   = 4'd2,
        MU_MULHSU = 4'd3,
        MU_MULHU  = 4'd4,
        MU_DIV    = 4'd5,
        MU_DIVU   = 4'd6,
        MU_REM    = 4'd7,
        MU_REMU   = 4'd8
    } mu_op_t;
endpackage

module mu_arbiter
    import mu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req_valid,
    input  mu_op_t          i_req_op    [NREQ],
    input  logic [XLEN-1:0] i_req_a     [NREQ],
    input  logic [XLEN-1:0] i_req_b     [NREQ],
    output logic [NREQ-1:0] o_req_ready,
    output logic [NREQ-1:0] o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_data  [NREQ],
    input  logic [NREQ-1:0] i_rsp_ready,
    input  logic [NREQ-1:0] i_flush,
    output mu_op_t          o_mu_op,
    output logic [XLEN-1:0] o_mu_a,
    output logic [XLEN-1:0] o_mu_b,
    input  logic [XLEN-1:0] i_mu_result,
    input  logic            i_mu_busy,
    input  logic            i_mu_done,
    output logic            o_err
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SUMW = PTRW + 1;
    localparam int TMRW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [PTRW-1:0] ptr_r;
    logic [PTRW-1:0] ptr_nxt_s;
    logic [PTRW-1:0] owner_r;
    logic [PTRW-1:0] grant_idx_s;
    logic            grant_vld_s;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] ready_s;
    logic            accept_s;
    logic            timeout_s;
    logic [TMRW-1:0] timer_r;
    logic            kill_r;
    logic            err_r;
    mu_op_t          mu_op_r;
    logic [XLEN-1:0] mu_a_r;
    logic [XLEN-1:0] mu_b_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [XLEN-1:0] rsp_data_r [NREQ];
    logic [NREQ-1:0] wr_s;
    logic [XLEN-1:0] wr_data_s;
    logic            unused_busy_s;

    // The mu's own busy flag adds nothing beyond done for this block.
    assign unused_busy_s = i_mu_busy;

    assign elig_s = i_req_valid & ~rsp_valid_r & ~i_flush;

    // Round-robin search: walk offsets from high to low so the lowest offset from ptr wins.
    always_comb begin
        logic [SUMW-1:0] idx_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_v       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_v = {1'b0, ptr_r} + SUMW'(k);
            if (idx_v >= SUMW'(NREQ)) begin
                idx_v = idx_v - SUMW'(NREQ);
            end else begin
                idx_v = idx_v;
            end
            if (elig_s[idx_v[PTRW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_v[PTRW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Grant handshake, pointer advance and watchdog condition.
    always_comb begin
        logic [SUMW-1:0] inc_v;
        ready_s   = '0;
        accept_s  = (state_r == ST_IDLE) && grant_vld_s;
        inc_v     = {1'b0, grant_idx_s} + SUMW'(1);
        ptr_nxt_s = (inc_v == SUMW'(NREQ)) ? '0 : inc_v[PTRW-1:0];
        timeout_s = (state_r == ST_RUN) && !i_mu_done && (timer_r == TMRW'(TIMEOUT - 1));
        if (accept_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // FSM next state: NOP ops complete in IDLE without touching the mu.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (i_req_op[grant_idx_s] != MU_NOP)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_mu_done || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Response buffer write request: NOP result at accept, mu result on an unkilled done.
    always_comb begin
        wr_s      = '0;
        wr_data_s = '0;
        if (accept_s && (i_req_op[grant_idx_s] == MU_NOP)) begin
            wr_s[grant_idx_s] = 1'b1;
            wr_data_s         = '0;
        end else if ((state_r == ST_RUN) && i_mu_done && !kill_r) begin
            wr_s[owner_r] = 1'b1;
            wr_data_s     = i_mu_result;
        end else begin
            wr_s = '0;
        end
    end

    // FSM state, latched operation and watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            timer_r <= '0;
            kill_r  <= 1'b0;
            err_r   <= 1'b0;
            mu_op_r <= MU_NOP;
            mu_a_r  <= '0;
            mu_b_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (timeout_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ptr_r   <= ptr_nxt_s;
                        owner_r <= grant_idx_s;
                        mu_op_r <= i_req_op[grant_idx_s];
                        mu_a_r  <= i_req_a[grant_idx_s];
                        mu_b_r  <= i_req_b[grant_idx_s];
                        timer_r <= '0;
                        kill_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    timer_r <= timer_r + TMRW'(1);
                    if (i_flush[owner_r]) begin
                        kill_r <= 1'b1;
                    end
                    // Dropping to NOP on exit keeps the mu from restarting on a stale op.
                    if (i_mu_done || timeout_s) begin
                        mu_op_r <= MU_NOP;
                    end
                end
                default: begin
                    mu_op_r <= MU_NOP;
                end
            endcase
        end
    end

    // Per-requester response buffers; flush wins over a same-cycle write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_r <= '0;
            for (int i = 0; i < NREQ; i++) begin
                rsp_data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_flush[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else if (wr_s[i]) begin
                    rsp_valid_r[i] <= 1'b1;
                    rsp_data_r[i]  <= wr_data_s;
                end else if (i_rsp_ready[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign o_req_ready = ready_s;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;
    assign o_mu_op     = mu_op_r;
    assign o_mu_a      = mu_a_r;
    assign o_mu_b      = mu_b_r;
    assign o_err       = err_r;

endmodule

// File: tb/tb_mu_arbiter.sv
// Directed bench for mu_arbiter: vector table for single ops plus hand-written
// sequences for arbitration, flush, blocking, watchdog and reset.
module tb_mu_arbiter;
    import mu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    mu_op_t      req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data [2];
    logic [1:0]  rsp_ready;
    logic [1:0]  flush;
    mu_op_t      mu_op;
    logic [31:0] mu_a, mu_b, mu_result;
    logic        mu_busy, mu_done, err;
    logic        hang;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mu_arbiter #(.NREQ(2), .TIMEOUT(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .i_rsp_ready(rsp_ready), .i_flush(flush),
        .o_mu_op(mu_op), .o_mu_a(mu_a), .o_mu_b(mu_b),
        .i_mu_result(mu_result), .i_mu_busy(mu_busy), .i_mu_done(mu_done), .o_err(err)
    );

    // Behavioural mu: samples op/a/b at its start cycle, done after 4 (mul) or 12 (div) cycles.
    function automatic logic [31:0] mu_calc(input mu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            MU_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            MU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            MU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            MU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            MU_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            MU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MU_REM:    return (b == 32'd0) ? a :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            MU_REMU:   return (b == 32'd0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    logic        busy_m;
    int          cnt_m, lat_m;
    logic [31:0] res_m;

    always @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
            cnt_m  <= 0;
        end else if (busy_m) begin
            if (cnt_m == lat_m - 1) busy_m <= 1'b0;
            else cnt_m <= cnt_m + 1;
        end else if (mu_op != MU_NOP && !hang) begin
            busy_m <= 1'b1;
            cnt_m  <= 1;
            lat_m  <= (mu_op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU}) ? 4 : 12;
            res_m  <= mu_calc(mu_op, mu_a, mu_b);
        end
    end

    assign mu_busy   = busy_m;
    assign mu_done   = busy_m && (cnt_m == lat_m - 1);
    assign mu_result = mu_done ? res_m : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int r, input int max, output int n);
        n = 1;
        while (!rsp_valid[r] && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        int          r;
        mu_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   n;
        vec_t v;

        vecs[0] = '{0, MU_MUL,   32'd7,           32'd6,           32'd42,          5};
        vecs[1] = '{1, MU_DIVU,  32'd100,         32'd0,           32'hFFFF_FFFF,  13};
        vecs[2] = '{0, MU_DIV,   32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,  13};
        vecs[3] = '{1, MU_REM,   32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,  13};
        vecs[4] = '{0, MU_MULHU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE,   5};
        vecs[5] = '{1, MU_NOP,   32'd5,           32'd6,           32'd0,           1};
        vecs[6] = '{0, MU_REMU,  32'd100,         32'd0,           32'd100,        13};
        vecs[7] = '{1, MU_MULH,  32'h8000_0000,   32'h8000_0000,   32'h4000_0000,   5};

        rst = 1'b1; hang = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b00; flush = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = MU_NOP; req_a[i] = 32'd0; req_b[i] = 32'd0;
        end
        repeat (3) cyc();
        chk("rst_mu_op", mu_op, MU_NOP);
        chk("rst_mu_a", mu_a, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data0", rsp_data[0], 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        rst = 1'b0;

        // Table: one op at a time, latency from accept to response visible.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            req_valid[v.r] = 1'b1; req_op[v.r] = v.op; req_a[v.r] = v.a; req_b[v.r] = v.b;
            #1;
            chk("vec_accept", req_ready[v.r], 1'b1);
            chk("vec_idle_op", mu_op, MU_NOP);
            cyc();
            req_valid = 2'b00;
            if (v.op != MU_NOP) chk("vec_run_op", mu_op, v.op);
            wait_rsp(v.r, 40, n);
            chk("vec_latency", n, v.lat);
            chk("vec_data", rsp_data[v.r], v.exp);
            rsp_ready[v.r] = 1'b1;
            cyc();
            rsp_ready = 2'b00;
            chk("vec_drain", rsp_valid, 2'b00);
        end

        // Round robin with ptr=0 (last grant was req1); op held T+1..T+4.
        req_valid = 2'b11;
        req_op[0] = MU_MUL; req_a[0] = 32'd3; req_b[0] = 32'd5;
        req_op[1] = MU_MUL; req_a[1] = 32'd9; req_b[1] = 32'd9;
        #1;
        chk("rr_first", req_ready, 2'b01);
        cyc();
        req_valid[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("rr_hold_op", mu_op, MU_MUL);
            chk("rr_run_ready", req_ready, 2'b00);
            cyc();
        end
        chk("rr_rsp0_valid", rsp_valid, 2'b01);
        chk("rr_rsp0_data", rsp_data[0], 32'd15);
        chk("rr_done_nop", mu_op, MU_NOP);
        chk("rr_second", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        chk("rr_restart_op", mu_op, MU_MUL);
        chk("rr_restart_a", mu_a, 32'd9);
        wait_rsp(1, 20, n);
        chk("rr_rsp1_lat", n, 5);
        chk("rr_rsp1_data", rsp_data[1], 32'd81);
        rsp_ready = 2'b11;
        cyc();
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        chk("rr_wrap", req_ready, 2'b01);
        cyc();
        req_valid[0] = 1'b0;
        wait_rsp(0, 20, n);
        chk("rr_wrap_second", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        wait_rsp(1, 20, n);
        chk("rr_wrap_rsp1", rsp_data[1], 32'd81);
        rsp_ready = 2'b11;
        cyc();
        rsp_ready = 2'b00;

        // Flush of RUN owner at T+3: op held to done, no response, req1 granted next IDLE.
        req_valid = 2'b01; req_op[0] = MU_REM; req_a[0] = 32'd17; req_b[0] = 32'd5;
        #1;
        chk("fl_accept", req_ready, 2'b01);
        cyc();
        req_valid = 2'b10; req_op[1] = MU_DIVU; req_a[1] = 32'd50; req_b[1] = 32'd7;
        for (int k = 1; k <= 12; k++) begin
            flush = (k == 3) ? 2'b01 : 2'b00;
            #1;
            chk("fl_hold_op", mu_op, MU_REM);
            chk("fl_run_ready", req_ready, 2'b00);
            chk("fl_no_rsp", rsp_valid[0], 1'b0);
            cyc();
        end
        flush = 2'b00;
        #1;
        chk("fl_discard", rsp_valid, 2'b00);
        chk("fl_next_grant", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        wait_rsp(1, 20, n);
        chk("fl_rsp1_data", rsp_data[1], 32'd7);
        rsp_ready = 2'b11;
        cyc();
        rsp_ready = 2'b00;

        // Flush in the done cycle beats the buffer write.
        req_valid = 2'b01; req_op[0] = MU_MUL; req_a[0] = 32'd2; req_b[0] = 32'd2;
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        flush = 2'b01;
        cyc();
        flush = 2'b00;
        chk("fld_no_rsp", rsp_valid, 2'b00);
        chk("fld_nop", mu_op, MU_NOP);

        // Flush clears a full buffer.
        req_valid = 2'b10; req_op[1] = MU_NOP;
        cyc();
        req_valid = 2'b00;
        chk("flb_full", rsp_valid, 2'b10);
        flush = 2'b10;
        cyc();
        flush = 2'b00;
        chk("flb_cleared", rsp_valid, 2'b00);

        // Full buffer blocks req0 until drained.
        req_valid = 2'b01; req_op[0] = MU_NOP;
        cyc();
        chk("blk_full", rsp_valid, 2'b01);
        req_valid = 2'b11;
        req_op[0] = MU_MUL; req_a[0] = 32'd4; req_b[0] = 32'd4;
        req_op[1] = MU_MUL; req_a[1] = 32'd6; req_b[1] = 32'd7;
        #1;
        chk("blk_only_req1", req_ready, 2'b10);
        cyc();
        req_valid[1] = 1'b0;
        for (int k = 1; k <= 4; k++) cyc();
        chk("blk_rsp1", rsp_valid, 2'b11);
        chk("blk_rsp1_data", rsp_data[1], 32'd42);
        chk("blk_still_blocked", req_ready, 2'b00);
        rsp_ready = 2'b01;
        cyc();
        rsp_ready = 2'b00;
        chk("blk_unblocked", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        wait_rsp(0, 20, n);
        chk("blk_rsp0_data", rsp_data[0], 32'd16);
        rsp_ready = 2'b11;
        cyc();
        rsp_ready = 2'b00;

        // Watchdog: mu never completes.
        hang = 1'b1;
        req_valid = 2'b01; req_op[0] = MU_MUL; req_a[0] = 32'd3; req_b[0] = 32'd3;
        #1;
        chk("wd_accept", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        for (int k = 1; k <= 32; k++) begin
            chk("wd_err_low", err, 1'b0);
            chk("wd_hold_op", mu_op, MU_MUL);
            cyc();
        end
        chk("wd_err_set", err, 1'b1);
        chk("wd_idle_op", mu_op, MU_NOP);
        chk("wd_no_rsp", rsp_valid, 2'b00);
        hang = 1'b0;
        req_valid = 2'b10; req_op[1] = MU_MUL; req_a[1] = 32'd5; req_b[1] = 32'd5;
        #1;
        chk("wd_next_accept", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        wait_rsp(1, 20, n);
        chk("wd_next_data", rsp_data[1], 32'd25);
        chk("wd_err_sticky", err, 1'b1);
        rsp_ready = 2'b11;
        cyc();
        rsp_ready = 2'b00;

        // Reset in the middle of a RUN.
        req_valid = 2'b01; req_op[0] = MU_DIV; req_a[0] = 32'd100; req_b[0] = 32'd3;
        cyc();
        req_valid = 2'b00;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_op", mu_op, MU_NOP);
        chk("mrst_a", mu_a, 32'd0);
        chk("mrst_b", mu_b, 32'd0);
        chk("mrst_rsp_valid", rsp_valid, 2'b00);
        chk("mrst_rsp_data1", rsp_data[1], 32'd0);
        chk("mrst_err", err, 1'b0);
        req_valid = 2'b11; req_op[0] = MU_NOP; req_op[1] = MU_NOP;
        #1;
        chk("mrst_ptr", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
